// File: rtl/acc_sequencer.sv
// Purpose: single-accumulator instruction sequencer that fetches, decodes and executes from a word memory.
// Latency: NOP/LDI/JMP/JZ take 2 cycles, LOAD/STORE/ADD/SUB take 3 cycles when acked in the first request cycle.
// Backpressure: mem_req and its address/data are held stable until mem_ack; there is no timeout.
module acc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] acc,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Accumulator update selected by the control path.
  typedef enum logic [2:0] {
    ACC_HOLD = 3'd0,
    ACC_IMM  = 3'd1,
    ACC_LOAD = 3'd2,
    ACC_ADD  = 3'd3,
    ACC_SUB  = 3'd4
  } acc_op_t;

  // Instruction word view of the instruction register.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] operand;
  } instr_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      state;
  state_t      state_nxt;
  instr_t      instr;
  logic [15:0] eff_addr;

  // Control strobes from the FSM to the datapath registers.
  logic        ir_ld;
  logic        pc_inc;
  logic        pc_ld_ea;
  acc_op_t     acc_op;
  logic        retire_inc;
  logic        illegal_set;

  assign instr    = instr_t'(ir);
  assign eff_addr = {4'h0, instr.operand};

  // Status flags decode straight from the state so reset clears them without a clock.
  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_MEM);
  assign halted = (state == S_HALT);

  // State register; reset forces IDLE immediately, which also drops mem_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, memory interface and datapath strobes.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc;
    mem_wdata   = 16'h0000;
    ir_ld       = 1'b0;
    pc_inc      = 1'b0;
    pc_ld_ea    = 1'b0;
    acc_op      = ACC_HOLD;
    retire_inc  = 1'b0;
    illegal_set = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        case (instr.opcode)
          OP_NOP: begin
            retire_inc = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_LDI: begin
            acc_op     = ACC_IMM;
            retire_inc = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_JMP: begin
            pc_ld_ea   = 1'b1;
            retire_inc = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_JZ: begin
            pc_ld_ea   = (acc == 16'h0000);
            retire_inc = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
            state_nxt = S_MEM;
          end
          OP_HALT: begin
            state_nxt = S_HALT;
          end
          default: begin
            illegal_set = 1'b1;
            state_nxt   = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        // ir and acc cannot change until the ack, so the request stays stable.
        mem_req  = 1'b1;
        mem_addr = eff_addr;
        if (instr.opcode == OP_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = acc;
        end
        if (mem_ack) begin
          case (instr.opcode)
            OP_LOAD: acc_op = ACC_LOAD;
            OP_ADD:  acc_op = ACC_ADD;
            OP_SUB:  acc_op = ACC_SUB;
            default: acc_op = ACC_HOLD;
          endcase
          retire_inc = 1'b1;
          state_nxt  = S_FETCH;
        end
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Architectural registers: ir, pc, acc, retire counter and the sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir      <= 16'h0000;
      pc      <= 16'h0000;
      acc     <= 16'h0000;
      retired <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      if (ir_ld) begin
        ir <= mem_rdata;
      end

      if (pc_inc) begin
        pc <= pc + 16'h0001;
      end else if (pc_ld_ea) begin
        pc <= eff_addr;
      end

      case (acc_op)
        ACC_IMM:  acc <= eff_addr;
        ACC_LOAD: acc <= mem_rdata;
        ACC_ADD:  acc <= acc + mem_rdata;
        ACC_SUB:  acc <= acc - mem_rdata;
        default:  acc <= acc;
      endcase

      if (retire_inc) begin
        retired <= retired + 16'h0001;
      end

      if (illegal_set) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Purpose: directed self-checking bench for acc_sequencer with a small word-memory responder.
// Latency: checks instruction cycle counts from start to HALT and ack-delay holding of requests.
// Backpressure: responder acks after a programmable number of wait cycles, or forces ack for negative tests.
module tb_acc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] acc;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          force_ack = 1'b0;
  int          cyc;

  acc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .acc       (acc),
    .pc        (pc),
    .ir        (ir),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Memory responder: decides ack for the coming rising edge on each falling edge.
  always @(negedge clk) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[11:0]];
    end else if (reset || !mem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      wait_cnt  = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[11:0]];
      if (mem_we) begin
        mem[mem_addr[11:0]] = mem_wdata;
      end
      wait_cnt = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = wait_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'h0000;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Steps cycles until HALT or the budget runs out; an expired budget fails halt_reached.
  task automatic run_halt(input string tag, input int budget, output int ncyc);
    ncyc = 0;
    while (!halted && ncyc < budget) begin
      @(posedge clk);
      #1;
      ncyc++;
    end
    chk({tag, "_halt_reached"}, {15'h0, halted}, 16'h0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_mem();
    #1;
    // Reset state while reset is held.
    chk("rst_mem_req",   {15'h0, mem_req}, 16'h0000);
    chk("rst_mem_we",    {15'h0, mem_we},  16'h0000);
    chk("rst_mem_addr",  mem_addr,  16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_acc",       acc,       16'h0000);
    chk("rst_pc",        pc,        16'h0000);
    chk("rst_ir",        ir,        16'h0000);
    chk("rst_retired",   retired,   16'h0000);
    chk("rst_busy",      {15'h0, busy},    16'h0000);
    chk("rst_halted",    {15'h0, halted},  16'h0000);
    chk("rst_illegal",   {15'h0, illegal}, 16'h0000);
    #10;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("idle_hold_busy",    {15'h0, busy},    16'h0000);
    chk("idle_hold_req",     {15'h0, mem_req}, 16'h0000);
    chk("idle_hold_halted",  {15'h0, halted},  16'h0000);

    // LDI 5; ADD [10]; STORE [11]; HALT with mem[10]=3.
    clear_mem();
    mem[16'h0000] = 16'h7005;
    mem[16'h0001] = 16'h3010;
    mem[16'h0002] = 16'h2011;
    mem[16'h0003] = 16'hF000;
    mem[16'h0010] = 16'h0003;
    ack_delay = 0;
    pulse_start();
    chk("p0_fetch_req",  {15'h0, mem_req}, 16'h0001);
    chk("p0_fetch_addr", mem_addr, 16'h0000);
    chk("p0_fetch_busy", {15'h0, busy}, 16'h0001);
    run_halt("p0", 50, cyc);
    chk("p0_cycles",   cyc[15:0], 16'd10);
    chk("p0_store",    mem[16'h0011], 16'h0008);
    chk("p0_acc",      acc, 16'h0008);
    chk("p0_retired",  retired, 16'h0003);
    chk("p0_pc",       pc, 16'h0004);
    chk("p0_busy",     {15'h0, busy}, 16'h0000);
    chk("p0_illegal",  {15'h0, illegal}, 16'h0000);
    chk("p0_halt_req", {15'h0, mem_req}, 16'h0000);

    // SUB wraps below zero.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h4010;
    mem[16'h0001] = 16'hF000;
    mem[16'h0010] = 16'h0001;
    pulse_start();
    run_halt("sub", 50, cyc);
    chk("sub_cycles",  cyc[15:0], 16'd5);
    chk("sub_acc",     acc, 16'hFFFF);
    chk("sub_retired", retired, 16'h0001);
    chk("sub_pc",      pc, 16'h0002);

    // JZ taken with acc=0.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h7000;
    mem[16'h0001] = 16'h6005;
    mem[16'h0005] = 16'hF000;
    pulse_start();
    run_halt("jz_t", 50, cyc);
    chk("jz_t_cycles",  cyc[15:0], 16'd6);
    chk("jz_t_pc",      pc, 16'h0006);
    chk("jz_t_retired", retired, 16'h0002);

    // JZ not taken with acc=1; HALT at 2 proves the fall-through fetch.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h7001;
    mem[16'h0001] = 16'h6005;
    mem[16'h0002] = 16'hF000;
    mem[16'h0005] = 16'hF000;
    pulse_start();
    run_halt("jz_n", 50, cyc);
    chk("jz_n_pc",      pc, 16'h0003);
    chk("jz_n_acc",     acc, 16'h0001);
    chk("jz_n_retired", retired, 16'h0002);

    // JMP forward.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h5007;
    mem[16'h0007] = 16'hF000;
    pulse_start();
    run_halt("jmp", 50, cyc);
    chk("jmp_cycles", cyc[15:0], 16'd4);
    chk("jmp_pc",     pc, 16'h0008);
    chk("jmp_ir",     ir, 16'hF000);

    // LOAD from memory.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h1020;
    mem[16'h0001] = 16'hF000;
    mem[16'h0020] = 16'hBEEF;
    pulse_start();
    run_halt("load", 50, cyc);
    chk("load_cycles",  cyc[15:0], 16'd5);
    chk("load_acc",     acc, 16'hBEEF);
    chk("load_retired", retired, 16'h0001);

    // Fetch acked after five wait cycles: six stable request cycles.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h7123;
    mem[16'h0001] = 16'hF000;
    ack_delay = 5;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk("dly_req",  {15'h0, mem_req}, 16'h0001);
      chk("dly_addr", mem_addr, 16'h0000);
      chk("dly_we",   {15'h0, mem_we}, 16'h0000);
      chk("dly_ir",   ir, 16'h0000);
      @(posedge clk);
      #1;
    end
    chk("dly_req_drop", {15'h0, mem_req}, 16'h0000);
    chk("dly_ir_load",  ir, 16'h7123);
    chk("dly_pc",       pc, 16'h0001);
    ack_delay = 0;
    run_halt("dly", 50, cyc);
    chk("dly_cycles", cyc[15:0], 16'd3);
    chk("dly_acc",    acc, 16'h0123);

    // Illegal opcode after one retired LDI; start afterwards has no effect.
    do_reset();
    clear_mem();
    mem[16'h0000] = 16'h7001;
    mem[16'h0001] = 16'h9ABC;
    pulse_start();
    run_halt("ill", 50, cyc);
    chk("ill_cycles",  cyc[15:0], 16'd4);
    chk("ill_flag",    {15'h0, illegal}, 16'h0001);
    chk("ill_ir",      ir, 16'h9ABC);
    chk("ill_retired", retired, 16'h0001);
    chk("ill_pc",      pc, 16'h0002);
    pulse_start();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("ill_start_halted",  {15'h0, halted}, 16'h0001);
    chk("ill_start_busy",    {15'h0, busy}, 16'h0000);
    chk("ill_start_req",     {15'h0, mem_req}, 16'h0000);
    chk("ill_start_pc",      pc, 16'h0002);
    chk("ill_start_retired", retired, 16'h0001);
    do_reset();
    chk("ill_cleared",  {15'h0, illegal}, 16'h0000);
    chk("ill_unhalted", {15'h0, halted}, 16'h0000);

    // Reset in MEM with the ack outstanding, then a stray ack in IDLE.
    clear_mem();
    mem[16'h0000] = 16'h1010;
    mem[16'h0010] = 16'h5555;
    ack_delay = 0;
    pulse_start();
    @(posedge clk);
    #1;
    chk("dec_req",   {15'h0, mem_req}, 16'h0000);
    chk("dec_we",    {15'h0, mem_we}, 16'h0000);
    chk("dec_wdata", mem_wdata, 16'h0000);
    chk("dec_addr",  mem_addr, 16'h0001);
    chk("dec_busy",  {15'h0, busy}, 16'h0001);
    ack_delay = 1000;
    @(posedge clk);
    #1;
    chk("mem_req",  {15'h0, mem_req}, 16'h0001);
    chk("mem_addr", mem_addr, 16'h0010);
    chk("mem_we",   {15'h0, mem_we}, 16'h0000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req",     {15'h0, mem_req}, 16'h0000);
    chk("arst_addr",    mem_addr, 16'h0000);
    chk("arst_pc",      pc, 16'h0000);
    chk("arst_ir",      ir, 16'h0000);
    chk("arst_acc",     acc, 16'h0000);
    chk("arst_retired", retired, 16'h0000);
    chk("arst_busy",    {15'h0, busy}, 16'h0000);
    chk("arst_halted",  {15'h0, halted}, 16'h0000);
    reset = 1'b0;
    force_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("late_ack_req",  {15'h0, mem_req}, 16'h0000);
    chk("late_ack_busy", {15'h0, busy}, 16'h0000);
    chk("late_ack_pc",   pc, 16'h0000);
    chk("late_ack_ir",   ir, 16'h0000);
    chk("late_ack_acc",  acc, 16'h0000);
    force_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
